writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_THREADS, default 4, hardware thread count; BITS_THREADS = $clog2(NUM_THREADS) local.
REQ-004 SHALL have ports, in order: clk in 1 (single clock, rising edge); rst in 1 (synchronous, active-high reset).
REQ-005 SHALL have ports: stall_w in 1 (hold W register); flush_w in 1 (insert bubble).
REQ-006 SHALL have M-stage inputs: valid_m 1, reg_write_m 1, res_src_m 2, funct3_m 3, alu_result_m DATA_WIDTH, read_data_m DATA_WIDTH, pc_plus4_m ADDRESS_WIDTH, rd_m 5, tid_m BITS_THREADS.
REQ-007 SHALL have register-file write outputs: reg_write_w out 1, rd_w out 5, result_w out DATA_WIDTH, tid_w out BITS_THREADS.
REQ-008 SHALL have scoreboard issue inputs: issue_valid_d 1, issue_reg_write_d 1, issue_rd_d 5, issue_tid_d BITS_THREADS.
REQ-009 SHALL have scoreboard query inputs rs1_d 5, rs2_d 5, tid_q BITS_THREADS; outputs busy_rs1 1, busy_rs2 1.
REQ-010 SHALL have output retire_count out 32: count of retired valid instructions.

Function
REQ-011 SHALL capture all M inputs into W registers on rising clk when rst=0, flush_w=0, stall_w=0; latency M->W exactly 1 cycle.
REQ-012 SHALL, when flush_w=1 (rst=0), clear W valid next cycle regardless of stall_w (flush beats stall).
REQ-013 SHALL, when stall_w=1 and flush_w=0, hold all W registers unchanged.
REQ-014 SHALL drive reg_write_w = valid_w AND reg_write_q AND (rd_w != 0); rd_w, tid_w direct from W registers.
REQ-015 SHALL select result_w by res_src_q: 00 alu_result, 01 load-extended read_data, 10 pc_plus4 (zero-extended/truncated to DATA_WIDTH), 11 alu_result.
REQ-016 SHALL extend loads by funct3_q with lane = alu_result_q[1:0]: 000 sign-ext byte[lane]; 001 sign-ext half[lane[1]]; 010 full word; 100 zero-ext byte[lane]; 101 zero-ext half[lane[1]]; any other code full word.
REQ-017 SHALL hold a scoreboard of NUM_THREADS x 32 pending bits; bit[t][0] permanently 0.
REQ-018 SHALL set bit[issue_tid_d][issue_rd_d] on clk when issue_valid_d AND issue_reg_write_d AND issue_rd_d != 0.
REQ-019 SHALL clear bit[tid_w][rd_w] on clk when reg_write_w=1 and stall_w=0.
REQ-020 SHALL, on simultaneous set and clear of same thread/register, leave bit set (set wins); different targets both take effect.
REQ-021 SHALL drive busy_rs1 = bit[tid_q][rs1_d], busy_rs2 = bit[tid_q][rs2_d], combinational from state, no same-cycle bypass of a clear.
REQ-022 SHALL increment retire_count by 1 on each clk where valid_w=1 and stall_w=0; wraps 0xFFFFFFFF -> 0.
REQ-023 SHALL not modify scoreboard or retire_count for flushed bubbles.

Reset
REQ-024 SHALL, on rst=1 at clk, clear valid_w, all W registers, all scoreboard bits, retire_count to 0; outputs reg_write_w=0, rd_w=0, tid_w=0, result_w=0, busy_rs1=busy_rs2=0.
REQ-025 SHALL give rst priority over flush_w, stall_w and issue; reset mid-operation discards in-flight W instruction and pending bits.

Verification
REQ-026 SHALL test ALU retire: valid_m=1, reg_write_m=1, res_src=00, alu=0x0000_1234, rd=5, tid=2 -> next cycle reg_write_w=1, rd_w=5, tid_w=2, result_w=0x1234, retire_count=1.
REQ-027 SHALL test loads: read_data=0x8070_F0A5, alu[1:0]=01: funct3 000 -> 0xFFFF_FFF0; 100 -> 0x0000_00F0; alu[1:0]=10, 001 -> 0xFFFF_8070; 101 -> 0x0000_8070.
REQ-028 SHALL test x0: reg_write_m=1, rd=0 -> reg_write_w=0, retire_count increments, no scoreboard change; issue rd=0 -> busy stays 0.
REQ-029 SHALL test scoreboard: issue tid1 rd7 -> next cycle busy_rs1=1 for tid_q=1, rs1=7, 0 for tid_q=0; writeback tid1 rd7 with same-cycle reissue tid1 rd7 -> bit remains 1; writeback alone -> 0 next cycle.
REQ-030 SHALL test stall/flush: stall_w=1 holds result_w and retire_count 2 cycles; flush_w=1 with stall_w=1 -> reg_write_w=0 next cycle; rst=1 mid-stream -> all outputs and busy bits 0 next cycle.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: pipeline W stage with load extension, result select, per-thread pending-register scoreboard and retire counter.
module writeback_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_THREADS = 4,
    localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_w,
    input  logic                     flush_w,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [1:0]               res_src_m,
    input  logic [2:0]               funct3_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    input  logic [4:0]               rd_m,
    input  logic [BITS_THREADS-1:0]  tid_m,
    output logic                     reg_write_w,
    output logic [4:0]               rd_w,
    output logic [DATA_WIDTH-1:0]    result_w,
    output logic [BITS_THREADS-1:0]  tid_w,
    input  logic                     issue_valid_d,
    input  logic                     issue_reg_write_d,
    input  logic [4:0]               issue_rd_d,
    input  logic [BITS_THREADS-1:0]  issue_tid_d,
    input  logic [4:0]               rs1_d,
    input  logic [4:0]               rs2_d,
    input  logic [BITS_THREADS-1:0]  tid_q,
    output logic                     busy_rs1,
    output logic                     busy_rs2,
    output logic [31:0]              retire_count
);
    logic                     valid_q, reg_write_q;
    logic [1:0]               res_src_q;
    logic [2:0]               funct3_q;
    logic [DATA_WIDTH-1:0]    alu_q, rdata_q, load_v;
    logic [ADDRESS_WIDTH-1:0] pc4_q;
    logic [7:0]               byte_v;
    logic [15:0]              half_v;
    logic [NUM_THREADS-1:0][31:0] sb, sb_n;

    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            res_src_q   <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            rd_w        <= '0;
            tid_w       <= '0;
        end else if (!stall_w) begin
            valid_q     <= valid_m;
            reg_write_q <= reg_write_m;
            res_src_q   <= res_src_m;
            funct3_q    <= funct3_m;
            alu_q       <= alu_result_m;
            rdata_q     <= read_data_m;
            pc4_q       <= pc_plus4_m;
            rd_w        <= rd_m;
            tid_w       <= tid_m;
        end
    end

    always_comb begin
        byte_v   = rdata_q[{alu_q[1:0], 3'b000} +: 8];
        half_v   = rdata_q[{alu_q[1], 4'b0000} +: 16];
        load_v   = funct3_q == 3'b000 ? {{(DATA_WIDTH-8){byte_v[7]}}, byte_v} :
                   funct3_q == 3'b001 ? {{(DATA_WIDTH-16){half_v[15]}}, half_v} :
                   funct3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_v} :
                   funct3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_v} : rdata_q;
        result_w = res_src_q == 2'b01 ? load_v :
                   res_src_q == 2'b10 ? DATA_WIDTH'(pc4_q) : alu_q;
        reg_write_w = valid_q && reg_write_q && rd_w != 5'd0;
    end

    // Set is applied after clear so a same-target reissue keeps the bit pending.
    always_comb begin
        sb_n = sb;
        if (reg_write_w && !stall_w)
            sb_n[tid_w][rd_w] = 1'b0;
        if (issue_valid_d && issue_reg_write_d && issue_rd_d != 5'd0)
            sb_n[issue_tid_d][issue_rd_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb           <= '0;
            retire_count <= '0;
        end else begin
            sb <= sb_n;
            if (valid_q && !stall_w)
                retire_count <= retire_count + 32'd1;
        end
    end

    assign busy_rs1 = sb[tid_q][rs1_d];
    assign busy_rs2 = sb[tid_q][rs2_d];
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vectors; expected writebacks queued at issue and checked by a negedge monitor.
module tb_writeback_unit;
    logic clk = 0, rst, stall_w, flush_w;
    logic valid_m, reg_write_m;
    logic [1:0] res_src_m;
    logic [2:0] funct3_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0] rd_m, rd_w, issue_rd_d, rs1_d, rs2_d;
    logic [1:0] tid_m, tid_w, issue_tid_d, tid_q;
    logic reg_write_w, issue_valid_d, issue_reg_write_d, busy_rs1, busy_rs2;
    logic [31:0] result_w, retire_count;
    int errors = 0, checks = 0;

    typedef struct packed {logic [4:0] rd; logic [1:0] tid; logic [31:0] res;} exp_t;
    exp_t q[$];

    writeback_unit dut (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .res_src_m(res_src_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
        .rd_m(rd_m), .tid_m(tid_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .tid_w(tid_w), .issue_valid_d(issue_valid_d), .issue_reg_write_d(issue_reg_write_d),
        .issue_rd_d(issue_rd_d), .issue_tid_d(issue_tid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .tid_q(tid_q), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && reg_write_w && !stall_w) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d tid=%0d result=%h, required no write", rd_w, tid_w, result_w);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rd_w !== e.rd || tid_w !== e.tid || result_w !== e.res) begin
                    errors++;
                    $display("FAIL wb_data: got rd=%0d tid=%0d result=%h, required rd=%0d tid=%0d result=%h",
                             rd_w, tid_w, result_w, e.rd, e.tid, e.res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic m(input logic v, input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                     input logic [31:0] rdat, input logic [31:0] pc4, input logic [4:0] rd, input logic [1:0] tid);
        valid_m = v; reg_write_m = v; res_src_m = src; funct3_m = f3; alu_result_m = alu;
        read_data_m = rdat; pc_plus4_m = pc4; rd_m = rd; tid_m = tid;
    endtask

    task automatic wb(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                      input logic [31:0] rdat, input logic [31:0] pc4, input logic [4:0] rd,
                      input logic [1:0] tid, input logic [31:0] res);
        m(1, src, f3, alu, rdat, pc4, rd, tid);
        q.push_back('{rd: rd, tid: tid, res: res});
        tick();
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic [1:0] tid);
        issue_valid_d = v; issue_reg_write_d = v; issue_rd_d = rd; issue_tid_d = tid;
    endtask

    task automatic query(input logic [1:0] t, input logic [4:0] r1, input logic [4:0] r2);
        tid_q = t; rs1_d = r1; rs2_d = r2;
        #1;
    endtask

    initial begin
        rst = 1; stall_w = 0; flush_w = 0;
        m(0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0);
        query(0, 0, 0);
        tick(); tick();
        rst = 0;
        chk("rst_reg_write", {31'd0, reg_write_w}, 0);
        chk("rst_rd_tid", {25'd0, rd_w, tid_w}, 0);
        chk("rst_result", result_w, 0);
        chk("rst_retire", retire_count, 0);
        query(1, 7, 31);
        chk("rst_busy", {30'd0, busy_rs1, busy_rs2}, 0);

        wb(2'b00, 3'b000, 32'h0000_1234, 0, 0, 5, 2, 32'h0000_1234);
        m(0, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_reg_write", {31'd0, reg_write_w}, 1);
        tick();
        chk("alu_retire", retire_count, 1);

        wb(2'b01, 3'b000, 32'h0000_0001, 32'h8070_F0A5, 0, 10, 0, 32'hFFFF_FFF0);
        wb(2'b01, 3'b100, 32'h0000_0001, 32'h8070_F0A5, 0, 11, 1, 32'h0000_00F0);
        wb(2'b01, 3'b001, 32'h0000_0002, 32'h8070_F0A5, 0, 12, 2, 32'hFFFF_8070);
        wb(2'b01, 3'b101, 32'h0000_0002, 32'h8070_F0A5, 0, 13, 3, 32'h0000_8070);
        wb(2'b01, 3'b010, 32'h0000_0003, 32'h8070_F0A5, 0, 14, 0, 32'h8070_F0A5);
        wb(2'b01, 3'b000, 32'h0000_0003, 32'h8070_F0A5, 0, 15, 1, 32'hFFFF_FF80);
        wb(2'b10, 3'b000, 32'hDEAD_BEEF, 0, 32'h0000_0104, 16, 2, 32'h0000_0104);
        wb(2'b11, 3'b000, 32'hDEAD_0000, 32'h1111_1111, 0, 17, 3, 32'hDEAD_0000);
        m(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("load_retire", retire_count, 9);

        m(1, 2'b00, 0, 32'h55, 0, 0, 0, 1);
        tick();
        m(0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_reg_write", {31'd0, reg_write_w}, 0);
        tick();
        chk("x0_retire", retire_count, 10);
        issue(1, 0, 1);
        tick();
        issue(0, 0, 0);
        query(1, 0, 0);
        chk("x0_busy", {30'd0, busy_rs1, busy_rs2}, 0);

        issue(1, 7, 1);
        tick();
        issue(0, 0, 0);
        query(1, 7, 8);
        chk("sb_set_t1", {30'd0, busy_rs1, busy_rs2}, 32'd2);
        query(0, 7, 8);
        chk("sb_other_thread", {30'd0, busy_rs1, busy_rs2}, 0);
        wb(2'b00, 0, 32'h77, 0, 0, 7, 1, 32'h77);
        m(0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 7, 1);
        tick();
        issue(0, 0, 0);
        query(1, 7, 0);
        chk("sb_set_wins", {31'd0, busy_rs1}, 1);
        wb(2'b00, 0, 32'h78, 0, 0, 7, 1, 32'h78);
        m(0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 9, 2);
        tick();
        issue(0, 0, 0);
        query(1, 7, 0);
        chk("sb_clear", {31'd0, busy_rs1}, 0);
        query(2, 0, 9);
        chk("sb_diff_target", {31'd0, busy_rs2}, 1);
        chk("sb_retire", retire_count, 12);

        wb(2'b00, 0, 32'h0000_ABCD, 0, 0, 20, 3, 32'h0000_ABCD);
        m(0, 0, 0, 0, 0, 0, 0, 0);
        stall_w = 1;
        tick();
        chk("stall1_result", result_w, 32'h0000_ABCD);
        chk("stall1_retire", retire_count, 12);
        tick();
        chk("stall2_result", result_w, 32'h0000_ABCD);
        chk("stall2_retire", retire_count, 12);
        stall_w = 0;
        tick();
        chk("unstall_retire", retire_count, 13);

        m(1, 2'b00, 0, 32'h1111, 0, 0, 21, 0);
        tick();
        m(0, 0, 0, 0, 0, 0, 0, 0);
        stall_w = 1; flush_w = 1;
        tick();
        stall_w = 0; flush_w = 0;
        chk("flush_reg_write", {31'd0, reg_write_w}, 0);
        tick();
        chk("flush_retire", retire_count, 13);

        issue(1, 3, 0);
        tick();
        issue(0, 0, 0);
        m(1, 2'b00, 0, 32'h4444, 0, 0, 4, 0);
        tick();
        m(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; stall_w = 1;
        issue(1, 5, 0);
        tick();
        rst = 0; stall_w = 0;
        issue(0, 0, 0);
        chk("mid_rst_reg_write", {31'd0, reg_write_w}, 0);
        chk("mid_rst_rd_tid", {25'd0, rd_w, tid_w}, 0);
        chk("mid_rst_result", result_w, 0);
        chk("mid_rst_retire", retire_count, 0);
        query(0, 3, 5);
        chk("mid_rst_busy", {30'd0, busy_rs1, busy_rs2}, 0);
        tick();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
